// File: rtl/cpu_alu_issue.sv
// ID/EX issue stage feeding cpu_alu: resolves operand forwarding, registers
// operands and control in a single-entry valid/ready slot, supports flush,
// and counts stall cycles with a saturating counter.
module cpu_alu_issue #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [DATA_W-1:0] in_rs1_data,
    input  logic [DATA_W-1:0] in_rs2_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic [2:0]        in_alu_control,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_reg_write,
    input  logic              fwd_em_we,
    input  logic [REG_AW-1:0] fwd_em_rd,
    input  logic [DATA_W-1:0] fwd_em_data,
    input  logic              fwd_mw_we,
    input  logic [REG_AW-1:0] fwd_mw_rd,
    input  logic [DATA_W-1:0] fwd_mw_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] input_1,
    output logic [DATA_W-1:0] input_2,
    output logic [2:0]        alu_control,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_write,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              accept;
    logic              stall;
    logic [DATA_W-1:0] op1_fwd;
    logic [DATA_W-1:0] op2_fwd;
    logic [DATA_W-1:0] op2_sel;

    // Slot can take a new op when empty or being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign stall    = out_valid && !out_ready && !flush;

    // Operand forwarding: EX/MEM beats MEM/WB, x0 is never forwarded.
    always_comb begin
        op1_fwd = in_rs1_data;
        op2_fwd = in_rs2_data;
        if ((in_rs1 != '0) && fwd_em_we && (fwd_em_rd == in_rs1)) begin
            op1_fwd = fwd_em_data;
        end else if ((in_rs1 != '0) && fwd_mw_we && (fwd_mw_rd == in_rs1)) begin
            op1_fwd = fwd_mw_data;
        end
        if ((in_rs2 != '0) && fwd_em_we && (fwd_em_rd == in_rs2)) begin
            op2_fwd = fwd_em_data;
        end else if ((in_rs2 != '0) && fwd_mw_we && (fwd_mw_rd == in_rs2)) begin
            op2_fwd = fwd_mw_data;
        end
        op2_sel = in_use_imm ? in_imm : op2_fwd;
    end

    // Slot occupancy: flush wins, then accept, then drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload captured only on accept; otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            input_1       <= '0;
            input_2       <= '0;
            alu_control   <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
        end else if (accept) begin
            input_1       <= op1_fwd;
            input_2       <= op2_sel;
            alu_control   <= in_alu_control;
            out_rd        <= in_rd;
            out_reg_write <= in_reg_write;
        end
    end

    // Saturating count of cycles the held op waits on downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_alu_issue.sv
// Self-checking bench for cpu_alu_issue: a rule-level model compared every
// negedge, plus directed literal checks.
module tb_cpu_alu_issue;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 5;
    localparam int unsigned CW  = 2;
    localparam int          SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rs1, in_rs2, in_rd;
    logic [DW-1:0] in_rs1_data, in_rs2_data, in_imm;
    logic          in_use_imm;
    logic [2:0]    in_alu_control;
    logic          in_reg_write;
    logic          fwd_em_we, fwd_mw_we;
    logic [AW-1:0] fwd_em_rd, fwd_mw_rd;
    logic [DW-1:0] fwd_em_data, fwd_mw_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] input_1, input_2;
    logic [2:0]    alu_control;
    logic [AW-1:0] out_rd;
    logic          out_reg_write;
    logic [CW-1:0] stall_cnt;

    int total  = 0;
    int passed = 0;
    bit started = 1'b0;

    cpu_alu_issue #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .in_alu_control(in_alu_control), .in_rd(in_rd),
        .in_reg_write(in_reg_write),
        .fwd_em_we(fwd_em_we), .fwd_em_rd(fwd_em_rd), .fwd_em_data(fwd_em_data),
        .fwd_mw_we(fwd_mw_we), .fwd_mw_rd(fwd_mw_rd), .fwd_mw_data(fwd_mw_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .input_1(input_1), .input_2(input_2), .alu_control(alu_control),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    // Operand value seen by the ALU for one source register.
    function automatic logic [DW-1:0] operand(input logic [AW-1:0] rs, input logic [DW-1:0] rf);
        if (rs == 0) return rf;
        if (fwd_em_we && fwd_em_rd == rs) return fwd_em_data;
        if (fwd_mw_we && fwd_mw_rd == rs) return fwd_mw_data;
        return rf;
    endfunction

    // Model: the op the ALU should currently see, and the stall tally.
    logic          m_valid;
    logic [DW-1:0] m_i1, m_i2;
    logic [2:0]    m_ctl;
    logic [AW-1:0] m_rd;
    logic          m_rw;
    int            m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_cnt   <= 0;
        end else begin
            if (m_valid && !out_ready && !flush) m_cnt <= (m_cnt + 1 > SAT) ? SAT : m_cnt + 1;
            if (flush) begin
                m_valid <= 1'b0;
            end else if (in_valid && (!m_valid || out_ready)) begin
                m_valid <= 1'b1;
                m_i1    <= operand(in_rs1, in_rs1_data);
                m_i2    <= in_use_imm ? in_imm : operand(in_rs2, in_rs2_data);
                m_ctl   <= in_alu_control;
                m_rd    <= in_rd;
                m_rw    <= in_reg_write;
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Continuous comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (started && rst_n) begin
            chk("m_out_valid", 32'(out_valid), 32'(m_valid));
            chk("m_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            chk("m_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
            if (m_valid) begin
                chk("m_input_1", input_1, m_i1);
                chk("m_input_2", input_2, m_i2);
                chk("m_alu_control", 32'(alu_control), 32'(m_ctl));
                chk("m_out_rd", 32'(out_rd), 32'(m_rd));
                chk("m_out_reg_write", 32'(out_reg_write), 32'(m_rw));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [AW-1:0] rs1, input logic [DW-1:0] d1,
                          input logic [AW-1:0] rs2, input logic [DW-1:0] d2,
                          input logic [2:0] ctl, input logic [AW-1:0] rd);
        in_rs1 = rs1; in_rs1_data = d1;
        in_rs2 = rs2; in_rs2_data = d2;
        in_alu_control = ctl; in_rd = rd; in_reg_write = 1'b1;
        in_use_imm = 1'b0; in_imm = '0;
    endtask

    task automatic set_fwd(input logic ew, input logic [AW-1:0] er, input logic [DW-1:0] ed,
                           input logic mw, input logic [AW-1:0] mr, input logic [DW-1:0] md);
        fwd_em_we = ew; fwd_em_rd = er; fwd_em_data = ed;
        fwd_mw_we = mw; fwd_mw_rd = mr; fwd_mw_data = md;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        set_op('0, '0, '0, '0, 3'd0, '0);
        in_reg_write = 1'b0;
        set_fwd(1'b0, '0, '0, 1'b0, '0, '0);

        // Reset / idle
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        started = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_input_1", input_1, 32'd0);
        chk("rst_input_2", input_2, 32'd0);
        chk("rst_alu_control", 32'(alu_control), 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_reg_write", 32'(out_reg_write), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic issue, no hazard
        tick();
        set_op(5'd3, 32'h10, 5'd4, 32'h20, 3'b010, 5'd7);
        in_valid = 1'b1;
        tick();
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_input_1", input_1, 32'h10);
        chk("basic_input_2", input_2, 32'h20);
        chk("basic_alu_control", 32'(alu_control), 32'd2);
        chk("basic_out_rd", 32'(out_rd), 32'd7);
        in_valid = 1'b0;
        tick();
        chk("basic_drain", 32'(out_valid), 32'd0);

        // EX/MEM wins over MEM/WB
        set_op(5'd5, 32'h1111, 5'd6, 32'h66, 3'b001, 5'd8);
        set_fwd(1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB);
        in_valid = 1'b1;
        tick();
        chk("fwd_em_prio", input_1, 32'hAAAA);
        chk("fwd_none_rs2", input_2, 32'h66);

        // Only MEM/WB hits rs2
        set_op(5'd1, 32'h11, 5'd5, 32'h55, 3'b011, 5'd9);
        set_fwd(1'b1, 5'd9, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB);
        tick();
        chk("fwd_mw_rs2", input_2, 32'hBBBB);
        chk("fwd_mw_rs1_rf", input_1, 32'h11);

        // x0 is never forwarded
        set_op(5'd0, 32'h0, 5'd2, 32'h22, 3'b100, 5'd10);
        set_fwd(1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB);
        tick();
        chk("fwd_x0", input_1, 32'h0);

        // Immediate overrides forwarded rs2
        set_op(5'd3, 32'h30, 5'd5, 32'h55, 3'b101, 5'd11);
        set_fwd(1'b1, 5'd5, 32'hAAAA, 1'b0, '0, '0);
        in_use_imm = 1'b1; in_imm = 32'hFFFF_FFFC;
        tick();
        chk("imm_select", input_2, 32'hFFFF_FFFC);
        set_fwd(1'b0, '0, '0, 1'b0, '0, '0);

        // Drain, then backpressure with saturation
        in_valid = 1'b0;
        tick();
        set_op(5'd3, 32'h100, 5'd4, 32'h200, 3'b110, 5'd12);
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        chk("bp_first", input_1, 32'h100);
        set_op(5'd3, 32'h300, 5'd4, 32'h400, 3'b111, 5'd13);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_input_1", input_1, 32'h100);
            chk("bp_stall_cnt", 32'(stall_cnt), 32'((k > 3) ? 3 : k));
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp_queued_valid", 32'(out_valid), 32'd1);
        chk("bp_queued_input_1", input_1, 32'h300);
        chk("bp_queued_ctl", 32'(alu_control), 32'd7);
        chk("bp_sat_hold", 32'(stall_cnt), 32'd3);

        // Flush squashes held and incoming op
        set_op(5'd1, 32'hC0C0, 5'd2, 32'hC1C1, 3'b001, 5'd14);
        out_ready = 1'b0; flush = 1'b1;
        tick();
        chk("flush_valid", 32'(out_valid), 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush_no_issue", 32'(out_valid), 32'd0);

        // Async reset mid-hold
        set_op(5'd1, 32'hD0D0, 5'd2, 32'hD1D1, 3'b010, 5'd15);
        in_valid = 1'b1;
        tick();
        tick();
        chk("hold_before_rst", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_cnt", 32'(stall_cnt), 32'd0);
        chk("async_rst_input_1", input_1, 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        #3 rst_n = 1'b1;
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
